// File: rtl/rr_arb8_if.sv
// Request/grant bundle for the eight-requester round-robin arbiter.
// Requesters hold req[i] high until done; gnt is the registered one-hot answer.
interface rr_arb8_if;
  // Handshake: req[i] is a level held by requester i. The request is accepted
  // at the edge where gnt[i] becomes 1. It stays accepted while req[i] and en
  // remain high. Dropping req[i] ends the transfer at the next edge. en low
  // revokes any grant at the next edge.
  logic       en;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       busy;
  logic       state_dbg;

  modport master (output en, req, input gnt, gnt_id, busy, state_dbg);
  modport slave  (input en, req, output gnt, gnt_id, busy, state_dbg);
endinterface

// File: rtl/rr_arb8.sv
// Eight-requester round-robin arbiter with grant hold and registered one-hot grant.
// Optional hold limit: define RR_ARB_MAX_HOLD_EN to cap a grant at MAX_HOLD cycles.
module rr_arb8 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input logic     clock,
    input logic     reset_n,
    rr_arb8_if.slave bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] gnt_q, gnt_d;
    logic [2:0] id_q, id_d;
    logic [2:0] ptr_q, ptr_d;
    logic       busy_q, busy_d;

    logic [2:0] win;
    logic [2:0] idx;
    logic       win_vld;
    logic       held;
    logic       force_rearb;

    // Walk from lowest priority (ptr) up to highest (ptr-1); the last hit wins.
    always_comb begin
        win     = 3'd0;
        win_vld = 1'b0;
        idx     = 3'd0;
        for (int d = 8; d >= 1; d--) begin
            idx = ptr_q - 3'(d);
            if (bus.req[idx]) begin
                win     = idx;
                win_vld = 1'b1;
            end
        end
    end

    assign held = (state_q == GRANT) && bus.en && bus.req[id_q];

`ifdef RR_ARB_MAX_HOLD_EN
    localparam int CW = $clog2(MAX_HOLD);
    logic [CW-1:0] hold_cnt;

    assign force_rearb = held && (hold_cnt == CW'(MAX_HOLD - 1));

    // Counts consecutive held cycles; any new grant, revoke or idle clears it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hold_cnt <= '0;
        end else if (held && !force_rearb) begin
            hold_cnt <= hold_cnt + CW'(1);
        end else begin
            hold_cnt <= '0;
        end
    end
`else
    assign force_rearb = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (bus.en && win_vld) begin
                    state_d = GRANT;
                    gnt_d   = 8'd1 << win;
                    id_d    = win;
                    ptr_d   = win;
                end
            end
            GRANT: begin
                if (!bus.en) begin
                    state_d = IDLE;
                    gnt_d   = 8'd0;
                    id_d    = 3'd0;
                end else if (held && !force_rearb) begin
                    state_d = GRANT;
                end else if (win_vld) begin
                    // ptr equals the holder here, so the releasing unit ranks last.
                    state_d = GRANT;
                    gnt_d   = 8'd1 << win;
                    id_d    = win;
                    ptr_d   = win;
                end else begin
                    state_d = IDLE;
                    gnt_d   = 8'd0;
                    id_d    = 3'd0;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 8'd0;
                id_d    = 3'd0;
            end
        endcase
        busy_d = (state_d == GRANT);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            gnt_q   <= 8'd0;
            id_q    <= 3'd0;
            ptr_q   <= 3'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_id    = id_q;
    assign bus.busy      = busy_q;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_rr_arb8.sv
// Self-checking bench for rr_arb8: directed scenarios plus randomized traffic
// compared against a rotation-order reference model.
module tb_rr_arb8;

  localparam int MAXH = 4;
`ifdef RR_ARB_MAX_HOLD_EN
  localparam bit MH = 1'b1;
`else
  localparam bit MH = 1'b0;
`endif

  logic clock;
  logic reset_n;
  int   tests_run;
  int   tests_failed;

  // Reference model: current holder (-1 = none), last winner, held-cycle count.
  int m_holder;
  int m_ptr;
  int m_cnt;

  logic [7:0] exp_q[$];

  rr_arb8_if bus ();

  rr_arb8 #(.MAX_HOLD(MAXH)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int pick(input int ptr, input logic [7:0] req);
    for (int d = 1; d <= 8; d++) begin
      int k;
      k = (ptr - d + 16) % 8;
      if (req[k]) return k;
    end
    return -1;
  endfunction

  function automatic logic [7:0] exp_gnt();
    return (m_holder < 0) ? 8'h00 : 8'(1 << m_holder);
  endfunction

  task automatic model_reset();
    m_holder = -1;
    m_ptr    = 0;
    m_cnt    = 0;
  endtask

  task automatic model_step();
    if (!bus.en) begin
      m_holder = -1;
      m_cnt    = 0;
    end else if (m_holder >= 0 && bus.req[m_holder] && !(MH && m_cnt == MAXH - 1)) begin
      m_cnt = m_cnt + 1;
    end else begin
      m_holder = pick(m_ptr, bus.req);
      if (m_holder >= 0) m_ptr = m_holder;
      m_cnt = 0;
    end
  endtask

  task automatic advance();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.en  = 1'b0;
    bus.req = 8'h00;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (bus.gnt !== 8'h00) begin
      tests_failed++; $display("FAIL reset_gnt: got %h expected 00", bus.gnt);
    end
    tests_run++;
    if (bus.gnt_id !== 3'd0) begin
      tests_failed++; $display("FAIL reset_gnt_id: got %0d expected 0", bus.gnt_id);
    end
    tests_run++;
    if (bus.busy !== 1'b0) begin
      tests_failed++; $display("FAIL reset_busy: got %b expected 0", bus.busy);
    end
  endtask

  task automatic test_sweep();
    logic [7:0] r;
    logic [7:0] e;
    do_reset();
    for (int i = 7; i >= 0; i--) exp_q.push_back(8'(1 << i));
    bus.en  = 1'b1;
    r       = 8'hff;
    bus.req = r;
    for (int i = 0; i < 8; i++) begin
      advance();
      e = exp_q.pop_front();
      tests_run++;
      if (bus.gnt !== e) begin
        tests_failed++; $display("FAIL sweep_gnt[%0d]: got %h expected %h", i, bus.gnt, e);
      end
      r       = r & ~e;
      bus.req = r;
    end
    advance();
    tests_run++;
    if (bus.gnt !== 8'h00 || bus.busy !== 1'b0) begin
      tests_failed++; $display("FAIL sweep_end: got gnt %h busy %b expected 00 0", bus.gnt, bus.busy);
    end
  endtask

  task automatic test_rotation();
    logic [7:0] reqs [4];
    logic [7:0] gnts [4];
    do_reset();
    bus.en  = 1'b1;
    bus.req = 8'h80;
    advance();
    bus.req = 8'h00;
    advance();
    reqs = '{8'b1001_1000, 8'b1000_1000, 8'b1000_0000, 8'b0000_0000};
    gnts = '{8'b0001_0000, 8'b0000_1000, 8'b1000_0000, 8'b0000_0000};
    for (int i = 0; i < 4; i++) begin
      bus.req = reqs[i];
      advance();
      tests_run++;
      if (bus.gnt !== gnts[i]) begin
        tests_failed++; $display("FAIL rotation[%0d]: got %h expected %h", i, bus.gnt, gnts[i]);
      end
    end
  endtask

  task automatic test_en_revoke();
    do_reset();
    bus.en  = 1'b1;
    bus.req = 8'h08;
    for (int i = 0; i < 3; i++) begin
      advance();
      tests_run++;
      if (bus.gnt !== 8'h08 || bus.gnt_id !== 3'd3) begin
        tests_failed++; $display("FAIL hold3[%0d]: got %h/%0d expected 08/3", i, bus.gnt, bus.gnt_id);
      end
    end
    bus.en = 1'b0;
    advance();
    tests_run++;
    if (bus.gnt !== 8'h00 || bus.busy !== 1'b0) begin
      tests_failed++; $display("FAIL revoke: got gnt %h busy %b expected 00 0", bus.gnt, bus.busy);
    end
    bus.en = 1'b1;
    advance();
    tests_run++;
    if (bus.gnt !== 8'h08 || bus.busy !== 1'b1) begin
      tests_failed++; $display("FAIL regrant: got gnt %h busy %b expected 08 1", bus.gnt, bus.busy);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.en  = 1'b1;
    bus.req = 8'h80;
    advance();
    advance();
    #3;
    reset_n = 1'b0;
    #1;
    tests_run++;
    if (bus.gnt !== 8'h00 || bus.gnt_id !== 3'd0 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: got %h/%0d/%b expected 00/0/0", bus.gnt, bus.gnt_id, bus.busy);
    end
    bus.req = 8'b0001_1000;
    #2;
    reset_n = 1'b1;
    model_reset();
    advance();
    tests_run++;
    if (bus.gnt !== 8'b0001_0000) begin
      tests_failed++; $display("FAIL post_reset: got %h expected 10", bus.gnt);
    end
  endtask

  task automatic test_idle();
    do_reset();
    bus.en  = 1'b1;
    bus.req = 8'h00;
    for (int i = 0; i < 10; i++) begin
      advance();
      tests_run++;
      if (bus.gnt !== 8'h00 || bus.busy !== 1'b0) begin
        tests_failed++; $display("FAIL idle[%0d]: got %h/%b expected 00/0", i, bus.gnt, bus.busy);
      end
    end
    bus.req = 8'h01;
    advance();
    tests_run++;
    if (bus.gnt !== 8'h01 || bus.gnt_id !== 3'd0 || bus.busy !== 1'b1) begin
      tests_failed++; $display("FAIL idle_wake: got %h/%0d/%b expected 01/0/1", bus.gnt, bus.gnt_id, bus.busy);
    end
  endtask

  task automatic test_random();
    logic [7:0] r;
    logic [7:0] e;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      bus.en = ($urandom_range(0, 15) != 0);
      r = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
      if ($urandom_range(0, 9) == 0) r = 8'h00;
      if (m_holder >= 0 && $urandom_range(0, 3) != 0) r[m_holder] = 1'b1;
      bus.req = r;
      advance();
      e = exp_gnt();
      tests_run++;
      if (bus.gnt !== e) begin
        tests_failed++; $display("FAIL rand_gnt[%0d]: got %h expected %h", i, bus.gnt, e);
      end
      tests_run++;
      if (bus.gnt_id !== 3'((m_holder < 0) ? 0 : m_holder) || bus.busy !== (m_holder >= 0)) begin
        tests_failed++;
        $display("FAIL rand_id_busy[%0d]: got %0d/%b expected holder %0d", i, bus.gnt_id, bus.busy, m_holder);
      end
      tests_run++;
      if ($countones(bus.gnt) > 1) begin
        tests_failed++; $display("FAIL rand_onehot[%0d]: got %h expected at most one bit", i, bus.gnt);
      end
    end
  endtask

`ifdef RR_ARB_MAX_HOLD_EN
  task automatic test_max_hold();
    logic [7:0] e;
    do_reset();
    bus.en  = 1'b1;
    bus.req = 8'b1000_0001;
    for (int n = 0; n < 16; n++) begin
      advance();
      e = (((n / MAXH) % 2) == 0) ? 8'h80 : 8'h01;
      tests_run++;
      if (bus.gnt !== e) begin
        tests_failed++; $display("FAIL max_hold_alt[%0d]: got %h expected %h", n, bus.gnt, e);
      end
    end
    bus.req = 8'b1000_0000;
    for (int n = 0; n < 12; n++) begin
      advance();
      tests_run++;
      if (bus.gnt !== 8'h80) begin
        tests_failed++; $display("FAIL max_hold_sole[%0d]: got %h expected 80", n, bus.gnt);
      end
    end
  endtask
`endif

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset_n      = 1'b0;
    bus.en       = 1'b0;
    bus.req      = 8'h00;
    model_reset();
    test_reset();
    test_sweep();
    test_rotation();
    test_en_revoke();
    test_async_reset();
    test_idle();
    test_random();
`ifdef RR_ARB_MAX_HOLD_EN
    test_max_hold();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/rr_arb8.md
# rr_arb8

Eight-requester round-robin arbiter with grant hold, built around the 8-bit priority-select function (en-gated, one-hot grant, highest index wins). It owns a shared single-user resource: it registers a one-hot grant, holds it while the winner keeps requesting, then rotates priority so every requester is eventually served. It sits between requesting units and the resource mux/enable.

## Interface
- MAX_HOLD, 16: maximum consecutive cycles one grant may be held. Used only with RR_ARB_MAX_HOLD_EN. Legal range 2..256.
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- en  in  1  arbitration enable; low blocks new grants and revokes any held grant
- req  in  8  request bits, one per requester, level-sensitive
- gnt  out  8  registered one-hot grant, or all zeros
- gnt_id  out  3  binary index of the granted requester; 0 when gnt==0
- busy  out  1  high whenever gnt!=0

## Operation
- State: IDLE (gnt==0) or GRANT (gnt one-hot).
- Also holds ptr[2:0], the index of the last issued grant.
- Search order: ptr-1, ptr-2, … down to ptr, modulo 8, so the last winner is lowest priority.
- Winner = first index in the search order with req set.
- Reset: gnt=0, gnt_id=0, busy=0, ptr=0, state IDLE, hold count 0. First search order is therefore 7,6,…,0, matching the priority-select function.
- IDLE, en=1, req!=0: grant the winner next cycle, ptr←winner, go to GRANT.
- IDLE, en=0 or req==0: stay IDLE.
- GRANT, en=1, req[gnt_id]=1: hold the grant; gnt, gnt_id and ptr are unchanged.
- GRANT, en=1, req[gnt_id]=0: re-arbitrate the same cycle, with no bubble.
  - Winner exists: grant it next cycle and set ptr←winner.
  - req==0: go to IDLE.
  - The releasing requester is lowest priority and can win only if it reasserts and is the sole requester.
- GRANT, en=0: gnt→0 next cycle, go to IDLE, ptr unchanged.
- ptr changes only when a grant is issued.
- Requests that rise and fall between clock edges are never seen.
- gnt is never multi-hot, and never non-zero while en was low at the previous edge.
- Async reset mid-grant clears all outputs immediately. The first post-reset arbitration uses ptr=0.

## Timing
- Grant latency: 1 cycle from the sampling edge (req/en) to the gnt update.
- Release-to-next-grant: 1 cycle. A dropped req at edge N means the new gnt is valid after edge N.
- Revocation on en low: 1 cycle.
- gnt, gnt_id and busy are all register outputs, with no combinational path from inputs.
- Simultaneous release, new requests and en=1 in one cycle: the rotation rule above applies.

## Configuration
- RR_ARB_MAX_HOLD_EN defined:
  - A hold counter (reset 0) increments on each GRANT cycle where the grant is held.
  - When the counter reaches MAX_HOLD-1 while still held, the grant is forced to re-arbitrate as if released, with the current holder lowest priority. Another requester wins next cycle.
  - If the holder is the only requester, it is re-granted and the counter clears.
  - The counter also clears on every new grant and on IDLE.
- RR_ARB_MAX_HOLD_EN undefined: no counter; a grant is held indefinitely while req[gnt_id]=1 and en=1. MAX_HOLD is ignored.

## Test plan
- Reset, then en=1, req=8'b1111_1111 held: gnt=8'b1000_0000 after 1 cycle. Each requester then drops its bit the cycle after being granted: grant order 7,6,5,4,3,2,1,0, one per cycle, never multi-hot.
- After the holder (7) releases, req=8'b1001_1000 with ptr=7: gnt=8'b0001_0000. Next release: gnt=8'b0000_1000. Next release: gnt=8'b1000_0000 (wrap).
- Hold the grant on 3 with en=1, then en=0: gnt=0, busy=0 next cycle. en=1 with req=8'b0000_1000: gnt=8'b0000_1000 after 1 cycle.
- Assert reset_n=0 asynchronously mid-grant: gnt, gnt_id and busy go to 0 without a clock edge. After release with req=8'b0001_1000: gnt=8'b0001_0000.
- en=1, req=0 for 10 cycles: gnt stays 0 and busy stays 0. Then req=8'b0000_0001: gnt=8'b0000_0001 one cycle later.
- With RR_ARB_MAX_HOLD_EN and MAX_HOLD=4: req=8'b1000_0001 held constant. gnt alternates 8'b1000_0000 for 4 cycles, then 8'b0000_0001 for 4 cycles, repeating. With req=8'b1000_0000 only, gnt stays 8'b1000_0000 continuously.
